// File: rtl/demux_tdm.sv
// demux_tdm: registered time-division 1:N demultiplexer.
// Slot words arrive one per valid cycle, framed by a start-of-frame marker.
// Each word is written into a shadow buffer at its slot index. The complete
// frame is published on y, together with a one-cycle frame_valid, only when
// the last slot arrives. Framing errors are flagged with a one-cycle sync_err.
module demux_tdm #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        d_in,
  input  logic                valid_in,
  input  logic                sof_in,
  output logic [N_CH*W-1:0]   y,
  output logic                frame_valid,
  output logic [SEL_W-1:0]    sel,
  output logic                locked,
  output logic                sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_ZERO = '0;
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  state_t             state;
  logic [W-1:0]       shadow [N_CH];
  logic [N_CH*W-1:0]  frame_next;

  // Completed frame: shadow slots 0..N_CH-2 plus the last word arriving now,
  // so the final slot lands on y in the same edge that accepts it.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < N_CH - 1; k++) begin
      frame_next[k*W +: W] = shadow[k];
    end
    frame_next[(N_CH-1)*W +: W] = d_in;
  end

  // Framing FSM, shadow buffer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      locked      <= 1'b0;
      sel         <= SEL_ZERO;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      // Strobes default low; they pulse for exactly one cycle when set below.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (valid_in) begin
        case (state)
          HUNT: begin
            // Only an SOF can bring us into alignment; other words are dropped.
            if (sof_in) begin
              shadow[0] <= d_in;
              sel       <= SEL_ONE;
              state     <= LOCKED;
              locked    <= 1'b1;
            end
          end
          LOCKED: begin
            if (sof_in) begin
              // SOF always restarts at slot 0; mid-frame it abandons the
              // partial frame and reports the misalignment. y is untouched.
              if (sel != SEL_ZERO) begin
                sync_err <= 1'b1;
              end
              shadow[0] <= d_in;
              sel       <= SEL_ONE;
            end else if (sel == SEL_ZERO) begin
              // A frame should have started here but no SOF came: lose lock.
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end else if (sel == SEL_LAST) begin
              y           <= frame_next;
              frame_valid <= 1'b1;
              sel         <= SEL_ZERO;
            end else begin
              shadow[sel] <= d_in;
              sel         <= sel + SEL_ONE;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            sel    <= SEL_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_tdm.sv
// Testbench for demux_tdm: directed scenarios followed by a randomized run,
// all checked cycle by cycle against a queue-based frame model.
module tb_demux_tdm;

  localparam int N_CH  = 4;
  localparam int W     = 1;
  localparam int SEL_W = 2;

  logic                clk;
  logic                rst_n;
  logic [W-1:0]        d_in;
  logic                valid_in;
  logic                sof_in;
  logic [N_CH*W-1:0]   y;
  logic                frame_valid;
  logic [SEL_W-1:0]    sel;
  logic                locked;
  logic                sync_err;

  demux_tdm #(.N_CH(N_CH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_in        (d_in),
    .valid_in    (valid_in),
    .sof_in      (sof_in),
    .y           (y),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: the words of the frame being collected, in arrival order.
  logic [W-1:0]       part_q [$];
  bit                 m_locked;
  logic [N_CH*W-1:0]  m_y;
  bit                 m_fv;
  bit                 m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"},           64'(y),           64'(m_y));
    chk({tag, ".frame_valid"}, 64'(frame_valid), 64'(m_fv));
    chk({tag, ".sync_err"},    64'(sync_err),    64'(m_err));
    chk({tag, ".sel"},         64'(sel),         64'(part_q.size() % N_CH));
    chk({tag, ".locked"},      64'(locked),      64'(m_locked));
  endtask

  // Apply one word's worth of framing rules to the model.
  task automatic model_accept(input logic s, input logic [W-1:0] d);
    if (!m_locked) begin
      if (s) begin
        part_q.delete();
        part_q.push_back(d);
        m_locked = 1;
      end
    end else if (s) begin
      if (part_q.size() != 0) m_err = 1;
      part_q.delete();
      part_q.push_back(d);
    end else if (part_q.size() == 0) begin
      m_err    = 1;
      m_locked = 0;
    end else begin
      part_q.push_back(d);
      if (part_q.size() == N_CH) begin
        for (int k = 0; k < N_CH; k++) m_y[k*W +: W] = part_q[k];
        m_fv = 1;
        part_q.delete();
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = v;
    sof_in   = s;
    d_in     = d;
    @(posedge clk);
    m_fv  = 0;
    m_err = 0;
    if (v) model_accept(s, d);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    sof_in   = 1'b1;
    d_in     = '1;
    @(posedge clk);
    part_q.delete();
    m_locked = 0;
    m_y      = '0;
    m_fv     = 0;
    m_err    = 0;
    #1 check_all(tag);
  endtask

  task automatic gap(input string tag);
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) step(tag, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  initial begin
    logic [N_CH-1:0] pat;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    d_in     = '0;
    part_q.delete();
    m_locked = 0;
    m_y      = '0;
    m_fv     = 0;
    m_err    = 0;

    // Reset held two cycles with valid/sof active.
    do_reset("reset0");
    do_reset("reset1");
    chk("reset_y", 64'(y), 64'(0));

    // Basic contiguous frame 1,0,0,0.
    step("basic0", 1'b1, 1'b1, 1'b1);
    step("basic1", 1'b1, 1'b0, 1'b0);
    step("basic2", 1'b1, 1'b0, 1'b0);
    step("basic3", 1'b1, 1'b0, 1'b0);
    chk("basic_y_const", 64'(y), 64'(4'b0001));
    chk("basic_fv_const", 64'(frame_valid), 64'(1));
    step("basic_idle", 1'b0, 1'b0, 1'b0);
    chk("basic_fv_drop", 64'(frame_valid), 64'(0));

    // Gapped walking-one frames.
    for (int f = 0; f < N_CH; f++) begin
      for (int k = 0; k < N_CH; k++) begin
        step("walk", 1'b1, (k == 0), (k == f));
        if (k != N_CH - 1) gap("walk_gap");
      end
      pat = N_CH'(1) << f;
      chk("walk_y_const", 64'(y), 64'(pat));
      gap("walk_hold");
      chk("walk_hold_y", 64'(y), 64'(pat));
    end

    // HUNT discard: words without SOF after reset are ignored.
    do_reset("hunt_rst");
    step("hunt_d0", 1'b1, 1'b0, 1'b1);
    step("hunt_d1", 1'b1, 1'b0, 1'b1);
    step("hunt_d2", 1'b1, 1'b0, 1'b1);
    step("hunt_f0", 1'b1, 1'b1, 1'b1);
    step("hunt_f1", 1'b1, 1'b0, 1'b1);
    step("hunt_f2", 1'b1, 1'b0, 1'b0);
    step("hunt_f3", 1'b1, 1'b0, 1'b1);
    chk("hunt_y_const", 64'(y), 64'(4'b1011));

    // Early SOF restarts the frame and pulses sync_err once.
    step("early0", 1'b1, 1'b1, 1'b1);
    step("early1", 1'b1, 1'b0, 1'b1);
    step("early_sof", 1'b1, 1'b1, 1'b0);
    chk("early_err_const", 64'(sync_err), 64'(1));
    chk("early_y_held", 64'(y), 64'(4'b1011));
    step("early_r1", 1'b1, 1'b0, 1'b0);
    step("early_r2", 1'b1, 1'b0, 1'b1);
    step("early_r3", 1'b1, 1'b0, 1'b1);
    chk("early_y_const", 64'(y), 64'(4'b1100));

    // Missing SOF after a completed frame drops lock.
    step("miss", 1'b1, 1'b0, 1'b1);
    chk("miss_err_const", 64'(sync_err), 64'(1));
    chk("miss_locked_const", 64'(locked), 64'(0));

    // Reset mid-frame discards the partial frame and clears y.
    step("mid0", 1'b1, 1'b1, 1'b1);
    step("mid1", 1'b1, 1'b1, 1'b1);
    do_reset("mid_rst");
    chk("mid_y_const", 64'(y), 64'(0));
    for (int i = 0; i < 4; i++) step("mid_post", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("mid_idle", 1'b0, 1'b0, 1'b0);

    // Randomized stream: mostly well-formed frames with occasional framing faults.
    for (int i = 0; i < 600; i++) begin
      logic v, s, d;
      v = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) s = $urandom_range(0, 1);
      else s = (part_q.size() == 0);
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      else step("rand", v, s, d);
    end

    // Full-rate back-to-back frames: frame_valid every N_CH cycles.
    do_reset("b2b_rst");
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N_CH; k++) step("b2b", 1'b1, (k == 0), $urandom_range(0, 1));
      chk("b2b_fv_const", 64'(frame_valid), 64'(1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
